dram_line_fetcher: RTL and testbench

Read-side counterpart to the pattern/framebuffer writer: fetches one scanline of 16-bit pixels from SDRAM through the SDRAM controller's Avalon-style master port and deposits them into one half of the on-chip line buffer (ocm port B). It sits between the SDRAM controller and the VGA scanout path. Reads are pipelined with a bounded number of outstanding requests. Halves alternate per line (ping-pong), so scanout reads one half while the other fills.

---
 rtl/dram_line_fetcher_if.sv | 20 ++
 rtl/dram_line_fetcher.sv | 136 +++++++++++++
 tb/tb_dram_line_fetcher.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_line_fetcher_if.sv
// Avalon-style read/write master bundle between the line fetcher and the SDRAM controller.
// master = fetcher side, slave = controller side.
interface dram_line_fetcher_if;
  logic [24:0] address;
  logic        read_n;
  logic        write_n;
  logic        waitrequest;
  logic [15:0] data_from_dram;
  logic        readdatavalid;

  modport master (
    output address, read_n, write_n,
    input  waitrequest, data_from_dram, readdatavalid
  );

  modport slave (
    input  address, read_n, write_n,
    output waitrequest, data_from_dram, readdatavalid
  );
endinterface

// File: rtl/dram_line_fetcher.sv
// Fetches one scanline of 16-bit pixels from SDRAM into one half of the ping-pong line buffer,
// keeping up to MAX_PENDING reads in flight.
module dram_line_fetcher #(
  parameter int unsigned LINE_WORDS  = 640,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                main_clk,
  input  logic                reset,
  input  logic                line_req,
  input  logic [9:0]          line_num,
  input  logic [24:0]         fb_base,
  output logic                busy,
  output logic                line_done,
  output logic                bank,
  output logic                overrun,
  dram_line_fetcher_if.master dram,
  output logic [15:0]         ocm_addr_b,
  output logic [15:0]         ocm_datain_b,
  output logic                ocm_we_b
);
  localparam logic [15:0] LineLen = 16'(LINE_WORDS);
  localparam logic [3:0]  PendMax = 4'(MAX_PENDING);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [24:0] start_q, start_d;
  logic [15:0] issued_q, issued_d;
  logic [15:0] written_q, written_d;
  logic [3:0]  pending_q, pending_d;
  logic [34:0] line_offset;
  logic        accept, active, take, fill;

  logic        busy_q, busy_d, done_q, done_d, bank_q, bank_d, overrun_q, overrun_d;
  logic        read_n_q, read_n_d;
  logic [24:0] addr_q, addr_d;
  logic [15:0] ocm_addr_q, ocm_addr_d, ocm_data_q, ocm_data_d;
  logic        ocm_we_q, ocm_we_d;

  assign accept      = (state_q == StIssue) && !read_n_q && !dram.waitrequest;
  assign active      = (state_q == StIssue) || (state_q == StDrain);
  assign take        = active && dram.readdatavalid;
  assign fill        = ~bank_q;
  assign line_offset = 35'(line_num) * 35'(LINE_WORDS);

  always_ff @(posedge main_clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    start_d   = start_q;
    issued_d  = issued_q;
    written_d = written_q;
    pending_d = pending_q;
    if (state_q == StIdle) begin
      if (line_req) begin
        start_d   = 25'(35'(fb_base) + line_offset);
        issued_d  = '0;
        written_d = '0;
        pending_d = '0;
      end
    end else begin
      issued_d  = issued_q + 16'(accept);
      written_d = written_q + 16'(take);
      pending_d = pending_q + 4'(accept) - 4'(take);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (line_req) state_d = StIssue;
      StIssue: if (issued_d == LineLen) state_d = StDrain;
      StDrain: if (written_q == LineLen) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from next-state values so every port comes straight off a flop.
  always_comb begin
    busy_d     = (state_d == StIssue) || (state_d == StDrain);
    done_d     = (state_d == StDone);
    bank_d     = bank_q ^ ((state_q == StDrain) && (state_d == StDone));
    overrun_d  = overrun_q | (line_req && (state_q != StIdle));
    read_n_d   = !((state_d == StIssue) && (pending_d < PendMax) && (issued_d < LineLen));
    addr_d     = read_n_d ? addr_q : start_d + 25'(issued_d);
    ocm_we_d   = take;
    ocm_addr_d = take ? {fill, written_q[14:0]} : ocm_addr_q;
    ocm_data_d = take ? dram.data_from_dram : ocm_data_q;
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      start_q    <= '0;
      issued_q   <= '0;
      written_q  <= '0;
      pending_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bank_q     <= 1'b0;
      overrun_q  <= 1'b0;
      read_n_q   <= 1'b1;
      addr_q     <= '0;
      ocm_we_q   <= 1'b0;
      ocm_addr_q <= '0;
      ocm_data_q <= '0;
    end else begin
      start_q    <= start_d;
      issued_q   <= issued_d;
      written_q  <= written_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bank_q     <= bank_d;
      overrun_q  <= overrun_d;
      read_n_q   <= read_n_d;
      addr_q     <= addr_d;
      ocm_we_q   <= ocm_we_d;
      ocm_addr_q <= ocm_addr_d;
      ocm_data_q <= ocm_data_d;
    end
  end

  assign busy         = busy_q;
  assign line_done    = done_q;
  assign bank         = bank_q;
  assign overrun      = overrun_q;
  assign dram.address = addr_q;
  assign dram.read_n  = read_n_q;
  assign dram.write_n = 1'b1;
  assign ocm_addr_b   = ocm_addr_q;
  assign ocm_datain_b = ocm_data_q;
  assign ocm_we_b     = ocm_we_q;
endmodule

// File: tb/tb_dram_line_fetcher.sv
// Bench for dram_line_fetcher: behavioural SDRAM responder plus a line-level scoreboard.
module tb_dram_line_fetcher;
  localparam int unsigned LW = 8;
  localparam int unsigned MP = 4;

  typedef struct {
    logic [24:0] base;
    logic [9:0]  num;
    int          lat;
    int          wpct;
    logic [24:0] exp_start;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_req;
  logic [9:0]  line_num;
  logic [24:0] fb_base;
  logic        busy, line_done, bank, overrun;
  logic [15:0] ocm_addr_b, ocm_datain_b;
  logic        ocm_we_b;

  int n_checks = 0;
  int n_errors = 0;
  int latency, wait_pct, cyc, tb_pending, done_cnt;
  bit force_wait;
  logic [24:0] acc_q[$];
  logic [31:0] wr_q[$];
  resp_t       resp_q[$];
  vec_t        vecs[$];
  logic        bank_model;

  always #5 clk = ~clk;

  dram_line_fetcher_if dram ();

  dram_line_fetcher #(.LINE_WORDS(LW), .MAX_PENDING(MP)) dut (
    .main_clk    (clk),
    .reset       (rst),
    .line_req    (line_req),
    .line_num    (line_num),
    .fb_base     (fb_base),
    .busy        (busy),
    .line_done   (line_done),
    .bank        (bank),
    .overrun     (overrun),
    .dram        (dram),
    .ocm_addr_b  (ocm_addr_b),
    .ocm_datain_b(ocm_datain_b),
    .ocm_we_b    (ocm_we_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input logic [24:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {7'd0, a[24:16]};
  endfunction

  function automatic logic [24:0] model_start(input logic [24:0] b, input logic [9:0] n);
    logic [63:0] s;
    s = 64'(b) + 64'(n) * 64'(LW);
    return s[24:0];
  endfunction

  // Controller model: random waitrequest, fixed read latency, in-order responses.
  initial begin
    logic acc, stalled, dv;
    logic [24:0] prev_addr;
    stalled = 1'b0;
    prev_addr = '0;
    cyc = 0;
    tb_pending = 0;
    done_cnt = 0;
    dram.waitrequest = 1'b0;
    dram.readdatavalid = 1'b0;
    dram.data_from_dram = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stalled && !rst) begin
        chk("stall_read_n_held", dram.read_n, 1'b0);
        chk("stall_addr_held", dram.address, prev_addr);
      end
      if (dram.read_n === 1'b0) chk("pending_below_max", tb_pending < MP, 1'b1);
      chk("write_n_const", dram.write_n, 1'b1);
      dram.waitrequest = force_wait || ($urandom_range(99) < wait_pct);
      acc = (dram.read_n === 1'b0) && !dram.waitrequest;
      if (acc) begin
        acc_q.push_back(dram.address);
        resp_q.push_back('{cyc + latency, pix(dram.address)});
      end
      dv = (resp_q.size() > 0) && (resp_q[0].due <= cyc);
      dram.readdatavalid = dv;
      if (dv) dram.data_from_dram = resp_q.pop_front().data;
      else    dram.data_from_dram = 16'($urandom);
      tb_pending = tb_pending + int'(acc) - int'(dv);
      stalled = (dram.read_n === 1'b0) && dram.waitrequest;
      prev_addr = dram.address;
      if (ocm_we_b === 1'b1) wr_q.push_back({ocm_addr_b, ocm_datain_b});
      if (line_done === 1'b1) done_cnt++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_line_done"}, line_done, 1'b0);
    chk({tag, "_bank"}, bank, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_read_n"}, dram.read_n, 1'b1);
    chk({tag, "_address"}, dram.address, 25'd0);
    chk({tag, "_ocm_we"}, ocm_we_b, 1'b0);
    chk({tag, "_ocm_addr"}, ocm_addr_b, 16'd0);
    chk({tag, "_ocm_data"}, ocm_datain_b, 16'd0);
  endtask

  task automatic run_line(input vec_t v, input int ovr_at);
    logic [24:0] ea;
    logic        exp_half;
    bit          got;
    int          n;
    latency = v.lat;
    wait_pct = v.wpct;
    acc_q.delete();
    wr_q.delete();
    done_cnt = 0;
    exp_half = ~bank_model;
    line_num = v.num;
    fb_base = v.base;
    line_req = 1'b1;
    @(negedge clk); #1;
    line_req = 1'b0;
    chk("busy_after_req", busy, 1'b1);
    chk("read_n_after_req", dram.read_n, 1'b0);
    got = 1'b0;
    n = 0;
    while (n < 3000 && !got) begin
      if (line_done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (n == ovr_at) begin
          line_req = 1'b1;
          line_num = v.num + 10'd1;
          fb_base = v.base + 25'd7;
        end else begin
          line_req = 1'b0;
        end
        @(negedge clk); #1;
        n++;
      end
    end
    line_req = 1'b0;
    chk("line_done_seen", got, 1'b1);
    if (got) begin
      bank_model = ~bank_model;
      chk("busy_at_done", busy, 1'b0);
      chk("bank_at_done", bank, bank_model);
      chk("writes_before_done", wr_q.size(), LW);
    end
    @(negedge clk); #1;
    chk("line_done_pulse", line_done, 1'b0);
    chk("done_count", done_cnt, 1);
    chk("accept_count", acc_q.size(), LW);
    chk("write_count", wr_q.size(), LW);
    for (int i = 0; i < LW; i++) begin
      ea = v.exp_start + 25'(i);
      if (i < acc_q.size()) chk("dram_addr", acc_q[i], ea);
      if (i < wr_q.size()) begin
        chk("ocm_addr", wr_q[i][31:16], {exp_half, 15'(i)});
        chk("ocm_data", wr_q[i][15:0], pix(ea));
      end
    end
  endtask

  initial begin
    int n;
    vec_t v;
    rst = 1'b1;
    line_req = 1'b0;
    line_num = '0;
    fb_base = '0;
    latency = 3;
    wait_pct = 0;
    force_wait = 1'b0;
    bank_model = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    vecs.push_back('{25'h0000100, 10'd2, 3, 0, 25'h0000110});
    vecs.push_back('{25'h1FFFFFC, 10'd0, 2, 0, 25'h1FFFFFC});
    vecs.push_back('{25'h0002000, 10'd5, 2, 50, 25'h0002028});
    vecs.push_back('{25'h0000040, 10'd1, 10, 0, 25'h0000048});
    vecs.push_back('{25'h1FFFFF0, 10'd1023, 4, 25, 25'h0001FE8});
    for (int i = 0; i < 6; i++) begin
      v.base = 25'($urandom);
      v.num = 10'($urandom_range(1023));
      v.lat = $urandom_range(8, 1);
      v.wpct = $urandom_range(60);
      v.exp_start = model_start(v.base, v.num);
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_line(vecs[i], -1);

    // Reset after three accepts while reads are still in flight.
    latency = 6;
    wait_pct = 0;
    acc_q.delete();
    line_num = 10'd3;
    fb_base = 25'h0001000;
    line_req = 1'b1;
    @(negedge clk); #1;
    line_req = 1'b0;
    n = 0;
    while (acc_q.size() < 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("three_accepts", acc_q.size(), 3);
    force_wait = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    wr_q.delete();
    bank_model = 1'b0;
    check_reset_outputs("midline_reset");
    force_wait = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("no_write_after_reset", wr_q.size(), 0);
    chk("no_accept_after_reset", acc_q.size(), 3);
    chk("idle_after_reset", busy, 1'b0);
    run_line('{25'h0003000, 10'd4, 3, 20, 25'h0003020}, -1);

    // LINE_REQ pulsed mid-fetch.
    chk("overrun_before", overrun, 1'b0);
    run_line('{25'h0000500, 10'd7, 4, 30, 25'h0000538}, 2);
    chk("overrun_set", overrun, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("overrun_held", overrun, 1'b1);
    chk("idle_after_overrun", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
